cd4028_driver: RTL and testbench
================================

# cd4028_driver

Registered BCD-to-decimal one-hot decoder with a valid/ready input handshake and timed output pulses. It is the decode-side counterpart of the 10-line-to-BCD priority encoder. It accepts one 4-bit BCD digit per transaction and drives exactly one of ten output lines for a fixed number of clock cycles. It then inserts an all-low break-before-make gap before accepting the next digit. It sits between digit-producing logic (encoder, counter, UART parser) and line-driving loads such as LED bars, relay/select lines or scanned displays.

## Interface
- HOLD_CYCLES, 4, cycles each decoded line stays high; legal range ≥1
- GAP_CYCLES, 1, cycles all outputs are forced low after a hold; legal range ≥0 (0 = no gap)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- i_valid  input  1  i carries a digit to transfer
- i  input  4  BCD digit code; 0–9 valid, 10–15 invalid
- i_ready  output  1  block can accept a digit this cycle
- o  output  10  one-hot decoded lines; o[k] high for digit k
- o_busy  output  1  hold or gap in progress
- o_err  output  1  one-cycle pulse: invalid code was accepted

## Operation
- One clock, `clk`. `rst` is synchronous and active-high. All outputs except i_ready are registered.
- FSM states: IDLE, DRIVE, GAP. Down-counter width is clog2(max(HOLD_CYCLES,GAP_CYCLES,2)).
- IDLE:
  - i_ready=1, o=0, o_busy=0.
  - Transfer occurs on an edge where i_valid & i_ready.
  - Valid code k (0–9): go to DRIVE, o <= 1<<k, counter <= HOLD_CYCLES-1.
  - Invalid code (10–15): remain IDLE, o stays 0, o_err <= 1 for one cycle. The transfer is consumed; no hold and no gap.
- DRIVE:
  - i_ready=0, o_busy=1, o holds the one-hot value.
  - Counter decrements each edge. On the edge where counter==0:
    - GAP_CYCLES>0: go to GAP, o <= 0, counter <= GAP_CYCLES-1.
    - GAP_CYCLES==0: go to IDLE, o <= 0.
- GAP:
  - i_ready=0, o_busy=1, o=0.
  - Counter decrements each edge. On counter==0, go to IDLE.
- i_ready = (state==IDLE) & ~rst, decoded combinationally from state.
- i is sampled only on the transfer edge. Changes on i or i_valid during DRIVE or GAP are ignored.
- o never has more than one bit set. o is never non-zero outside DRIVE.
- o_err is low except for the single cycle after an invalid transfer.

## Timing
- Reset: while rst=1 at an edge, state<=IDLE, o<=0, o_err<=0, counter<=0. i_ready is 0 while rst is high. o_busy is 0 after the edge.
- Reset mid-DRIVE or mid-GAP: o clears on that same edge. No gap is inserted and the pending digit is discarded.
- For a valid transfer on edge t:
  - o is one-hot for edges t+1 … t+HOLD_CYCLES.
  - o=0 and o_busy=1 for t+HOLD_CYCLES+1 … t+HOLD_CYCLES+GAP_CYCLES.
  - i_ready=1 from the cycle after edge t+HOLD_CYCLES+GAP_CYCLES.
- Max throughput is one digit per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Invalid transfer on edge t: o_err=1 during cycle t+1 only. i_ready stays 1, so a back-to-back transfer can occur on edge t+1.
- i_valid held continuously: a new transfer occurs on the first IDLE cycle.

## Test plan
- Reset: assert rst 2 cycles with i_valid=1, i=5 -> o=0, o_busy=0, o_err=0, i_ready=0 during reset, and no transfer occurs.
- Single digit (HOLD=4, GAP=1): transfer i=3 at edge t -> o=10'b0000001000 for edges t+1..t+4; o=0 with o_busy=1 at t+5; i_ready=1 after edge t+5.
- Sweep: back-to-back i_valid=1 with i=0..9 -> each o equals 1<<i for exactly 4 cycles, a 1-cycle all-zero gap separates each digit, and o never has two bits set.
- Invalid codes: transfer i=10, then i=15 on the next cycle -> o stays 0, o_err pulses once per code, and i_ready stays 1.
- Reset mid-operation: transfer i=9, assert rst at the 2nd DRIVE cycle -> o=0 on that edge, state IDLE, and a following i=1 transfer gives o=10'b0000000010.
- GAP_CYCLES=0, HOLD_CYCLES=1 build: continuous i=7,8 -> o=10'b0010000000 for 1 cycle, o=0 for 1 cycle (IDLE accept cycle), then o=10'b0100000000.

Source files
------------

// File: rtl/cd4028_driver.sv
// Registered BCD-to-decimal one-hot decoder with valid/ready intake,
// timed output hold and an all-low break-before-make gap.
module cd4028_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [3:0] i,
  output logic       i_ready,
  output logic [9:0] o,
  output logic       o_busy,
  output logic       o_err
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int CW     = $clog2(MAX_C);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    o_q, o_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  // next-state, counter and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_d = 10'd0;
        if (i_valid) begin
          if (i <= 4'd9) begin
            state_d = S_DRIVE;
            o_d     = 10'd1 << i;
            cnt_d   = CW'(HOLD_CYCLES - 1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CW'(0)) begin
          o_d = 10'd0;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        o_d = 10'd0;
        if (cnt_q == CW'(0)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        o_d     = 10'd0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      o_q     <= 10'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign i_ready = (state_q == S_IDLE) & ~rst;
  assign o       = o_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_cd4028_driver.sv
// Randomized and directed bench for cd4028_driver; two builds (HOLD=4/GAP=1 and
// HOLD=1/GAP=0) share stimulus and are checked against a remaining-time model.
module tb_cd4028_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic [3:0] i;

  logic       rdy_a, busy_a, err_a;
  logic [9:0] o_a;
  logic       rdy_b, busy_b, err_b;
  logic [9:0] o_b;

  int n_chk  = 0;
  int n_pass = 0;

  // model: cycles of busy time left, latched digit, pending error pulse
  int   left [2];
  int   dig  [2];
  bit   merr [2];
  bit   took [2];

  always #5 clk = ~clk;

  cd4028_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i(i),
    .i_ready(rdy_a), .o(o_a), .o_busy(busy_a), .o_err(err_a)
  );

  cd4028_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i(i),
    .i_ready(rdy_b), .o(o_b), .o_busy(busy_b), .o_err(err_b)
  );

  function automatic int hold_of(input int n);
    return (n == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int n);
    return (n == 0) ? 1 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // one clock: drive at negedge, check ready, update model at posedge, check outputs
  task automatic cycle(input bit r, input bit v, input logic [3:0] d);
    logic [9:0] exp_o;
    @(negedge clk);
    rst = r; i_valid = v; i = d;
    #1;
    check_eq("ready0", {31'd0, rdy_a}, {31'd0, (left[0] == 0) && !r});
    check_eq("ready1", {31'd0, rdy_b}, {31'd0, (left[1] == 0) && !r});
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      took[n] = 1'b0;
      if (r) begin
        left[n] = 0; merr[n] = 1'b0; dig[n] = 0;
      end else begin
        merr[n] = 1'b0;
        if (left[n] > 0) left[n]--;
        else if (v) begin
          took[n] = 1'b1;
          if (d <= 4'd9) begin
            dig[n]  = int'(d);
            left[n] = hold_of(n) + gap_of(n);
          end else begin
            merr[n] = 1'b1;
          end
        end
      end
    end
    #1;
    for (int n = 0; n < 2; n++) begin
      exp_o = (left[n] > gap_of(n)) ? (10'd1 << dig[n]) : 10'd0;
      check_eq($sformatf("o%0d", n), {22'd0, (n == 0) ? o_a : o_b}, {22'd0, exp_o});
      check_eq($sformatf("busy%0d", n), {31'd0, (n == 0) ? busy_a : busy_b}, {31'd0, left[n] > 0});
      check_eq($sformatf("err%0d", n), {31'd0, (n == 0) ? err_a : err_b}, {31'd0, merr[n]});
      check_eq($sformatf("onehot%0d", n), {31'd0, $countones((n == 0) ? o_a : o_b) <= 1}, 32'd1);
    end
  endtask

  initial begin
    int idx;
    int guard;
    for (int n = 0; n < 2; n++) begin
      left[n] = 0; dig[n] = 0; merr[n] = 1'b0; took[n] = 1'b0;
    end
    rst = 1'b1; i_valid = 1'b1; i = 4'd5;

    // reset with a digit offered: nothing may transfer
    repeat (2) cycle(1'b1, 1'b1, 4'd5);
    cycle(1'b0, 1'b0, 4'd0);

    // single digit 3, then idle long enough to return to ready
    cycle(1'b0, 1'b1, 4'd3);
    check_eq("single_o", {22'd0, o_a}, 32'h008);
    repeat (7) cycle(1'b0, 1'b0, 4'd3);

    // sweep 0..9 with valid held: advance digit on each transfer of build A
    idx = 0; guard = 0;
    while (idx < 10 && guard < 200) begin
      cycle(1'b0, 1'b1, 4'(idx));
      if (took[0]) idx++;
      guard++;
    end
    check_eq("sweep_done", idx, 32'd10);
    repeat (6) cycle(1'b0, 1'b0, 4'd0);

    // invalid codes back to back
    cycle(1'b0, 1'b1, 4'd10);
    cycle(1'b0, 1'b1, 4'd15);
    cycle(1'b0, 1'b0, 4'd0);

    // reset during the second drive cycle of digit 9, then digit 1
    cycle(1'b0, 1'b1, 4'd9);
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
    check_eq("midrst_o", {22'd0, o_a}, 32'd0);
    cycle(1'b0, 1'b1, 4'd1);
    check_eq("after_rst_o", {22'd0, o_a}, 32'h002);
    repeat (6) cycle(1'b0, 1'b0, 4'd0);

    // continuous 7 then 8 (build B shows 7, accept gap, 8)
    cycle(1'b0, 1'b1, 4'd7);
    check_eq("b_seven", {22'd0, o_b}, 32'h080);
    cycle(1'b0, 1'b1, 4'd8);
    check_eq("b_gap", {22'd0, o_b}, 32'd0);
    cycle(1'b0, 1'b1, 4'd8);
    check_eq("b_eight", {22'd0, o_b}, 32'h100);
    repeat (6) cycle(1'b0, 1'b0, 4'd0);

    // random traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
